piso_serializer: RTL and testbench

Parametrised parallel-in/serial-out converter with a valid/ready word input, a one-word holding buffer and a bit-rate enable. It is the next-generation serializer for the team's serial-link datapath: configurable width and bit order, gap-free back-to-back words, and per-bit framing flags for the downstream line encoder.

---
 rtl/piso_serializer_pkg.sv | 9 +
 rtl/piso_hold_buf.sv | 32 +++
 rtl/piso_serializer.sv | 109 ++++++++++
 tb/tb_piso_serializer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/piso_serializer_pkg.sv
// Shared helpers for the parallel-in/serial-out serializer.
package piso_serializer_pkg;

    // Bit-counter width for a word of data_w bits, never narrower than one bit.
    function automatic int unsigned piso_cnt_w(input int unsigned data_w);
        return (data_w > 1) ? $clog2(data_w) : 1;
    endfunction

endpackage

// File: rtl/piso_hold_buf.sv
// One-entry holding register: captures a word on load, releases it on drain.
module piso_hold_buf #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_drain,
    output logic              o_full,
    output logic [DATA_W-1:0] o_data
);

    logic              r_full;
    logic [DATA_W-1:0] r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (i_load) begin
            r_full <= 1'b1;
            r_data <= i_data;
        end else if (i_drain) begin
            r_full <= 1'b0;
        end
    end

    assign o_full = r_full;
    assign o_data = r_data;

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out converter with a one-word holding buffer, bit-rate strobe
// and per-bit framing flags.
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter logic        IDLE_LEVEL = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [DATA_W-1:0] i_in_data,
    input  logic              i_bit_en,
    output logic              o_dout,
    output logic              o_dout_valid,
    output logic              o_frame_start,
    output logic              o_frame_last
);

    localparam int unsigned CNT_W = piso_cnt_w(DATA_W);

    logic [DATA_W-1:0] r_sreg;
    logic [DATA_W-1:0] w_sreg_d;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_d;
    logic              r_active;
    logic              w_active_d;

    logic              w_hold_full;
    logic [DATA_W-1:0] w_hold_data;
    logic              w_hold_load;
    logic              w_hold_drain;

    logic              w_accept;
    logic              w_consume;
    logic              w_last;
    logic [DATA_W-1:0] w_sreg_shifted;

    assign o_in_ready = !w_hold_full;
    assign w_accept   = i_in_valid && !w_hold_full;
    assign w_consume  = r_active && i_bit_en;
    assign w_last     = (r_cnt == CNT_W'(DATA_W - 1));

    // Vacated end fills with zeros; those bits never reach the output.
    assign w_sreg_shifted = MSB_FIRST ? {r_sreg[DATA_W-2:0], 1'b0}
                                      : {1'b0, r_sreg[DATA_W-1:1]};

    always_comb begin
        w_sreg_d     = r_sreg;
        w_cnt_d      = r_cnt;
        w_active_d   = r_active;
        w_hold_drain = 1'b0;
        if (!r_active) begin
            if (w_accept) begin
                w_sreg_d   = i_in_data;
                w_cnt_d    = '0;
                w_active_d = 1'b1;
            end
        end else if (w_consume && !w_last) begin
            w_sreg_d = w_sreg_shifted;
            w_cnt_d  = r_cnt + CNT_W'(1);
        end else if (w_consume) begin
            w_cnt_d = '0;
            if (w_hold_full) begin
                w_sreg_d     = w_hold_data;
                w_hold_drain = 1'b1;
            end else if (w_accept) begin
                w_sreg_d = i_in_data;
            end else begin
                w_active_d = 1'b0;
            end
        end
    end

    // A word arriving while busy is parked unless it is loaded straight into the shifter.
    assign w_hold_load = r_active && w_accept && !(w_consume && w_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sreg   <= '0;
            r_cnt    <= '0;
            r_active <= 1'b0;
        end else begin
            r_sreg   <= w_sreg_d;
            r_cnt    <= w_cnt_d;
            r_active <= w_active_d;
        end
    end

    piso_hold_buf #(
        .DATA_W (DATA_W)
    ) u_hold_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_hold_load),
        .i_data  (i_in_data),
        .i_drain (w_hold_drain),
        .o_full  (w_hold_full),
        .o_data  (w_hold_data)
    );

    assign o_dout        = r_active ? (MSB_FIRST ? r_sreg[DATA_W-1] : r_sreg[0]) : IDLE_LEVEL;
    assign o_dout_valid  = r_active;
    assign o_frame_start = r_active && (r_cnt == '0);
    assign o_frame_last  = r_active && w_last;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: three configurations driven from vector tables
// and hand-written sequences for back-to-back words and asynchronous reset.
module tb_piso_serializer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // A: DATA_W=4, MSB first, idle 0
    logic       a_valid, a_be, a_ready, a_dout, a_dv, a_fs, a_fl;
    logic [3:0] a_data;
    // B: DATA_W=8, LSB first, idle 0
    logic       b_valid, b_be, b_ready, b_dout, b_dv, b_fs, b_fl;
    logic [7:0] b_data;
    // C: DATA_W=4, MSB first, idle 1
    logic       c_valid, c_be, c_ready, c_dout, c_dv, c_fs, c_fl;
    logic [3:0] c_data;

    piso_serializer #(.DATA_W(4), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_a (
        .clk(clk), .rst_n(rst_n), .i_in_valid(a_valid), .o_in_ready(a_ready),
        .i_in_data(a_data), .i_bit_en(a_be), .o_dout(a_dout), .o_dout_valid(a_dv),
        .o_frame_start(a_fs), .o_frame_last(a_fl)
    );

    piso_serializer #(.DATA_W(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_b (
        .clk(clk), .rst_n(rst_n), .i_in_valid(b_valid), .o_in_ready(b_ready),
        .i_in_data(b_data), .i_bit_en(b_be), .o_dout(b_dout), .o_dout_valid(b_dv),
        .o_frame_start(b_fs), .o_frame_last(b_fl)
    );

    piso_serializer #(.DATA_W(4), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) u_c (
        .clk(clk), .rst_n(rst_n), .i_in_valid(c_valid), .o_in_ready(c_ready),
        .i_in_data(c_data), .i_bit_en(c_be), .o_dout(c_dout), .o_dout_valid(c_dv),
        .o_frame_start(c_fs), .o_frame_last(c_fl)
    );

    // Expected outputs describe the cycle in which the inputs are applied.
    typedef struct packed {
        logic       valid;
        logic [3:0] data;
        logic       be;
        logic [4:0] exp;   // {dout, dout_valid, frame_start, frame_last, in_ready}
    } vec_t;

    vec_t va[$];
    vec_t vc[$];

    function automatic vec_t v(input logic valid, input logic [3:0] data, input logic be,
                               input logic [4:0] exp);
        vec_t t;
        t.valid = valid;
        t.data  = data;
        t.be    = be;
        t.exp   = exp;
        return t;
    endfunction

    task automatic chk(input string name, input int idx, input logic [4:0] act,
                       input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d]: {dout,dv,fs,fl,rdy} got %b expected %b", name, idx, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [0:15] b_bits;
        logic [4:0]  b_exp;

        // Single word MSB first, then paced strobe with a held word, then direct reload.
        va.push_back(v(1'b0, 4'b0000, 1'b1, 5'b00001));   // strobe while idle
        va.push_back(v(1'b1, 4'b1011, 1'b1, 5'b00001));   // c0 accept
        va.push_back(v(1'b0, 4'b0000, 1'b1, 5'b11101));
        va.push_back(v(1'b0, 4'b0000, 1'b1, 5'b01001));
        va.push_back(v(1'b0, 4'b0000, 1'b1, 5'b11001));
        va.push_back(v(1'b0, 4'b0000, 1'b1, 5'b11011));
        va.push_back(v(1'b0, 4'b0000, 1'b0, 5'b00001));   // c5 idle
        va.push_back(v(1'b1, 4'b1001, 1'b0, 5'b00001));   // p0 accept 1001
        va.push_back(v(1'b1, 4'b0110, 1'b0, 5'b11101));   // p1 0110 into hold
        va.push_back(v(1'b0, 4'b0000, 1'b1, 5'b11100));
        va.push_back(v(1'b0, 4'b0000, 1'b0, 5'b01000));
        va.push_back(v(1'b0, 4'b0000, 1'b0, 5'b01000));
        va.push_back(v(1'b0, 4'b0000, 1'b1, 5'b01000));
        va.push_back(v(1'b0, 4'b0000, 1'b0, 5'b01000));
        va.push_back(v(1'b0, 4'b0000, 1'b0, 5'b01000));
        va.push_back(v(1'b0, 4'b0000, 1'b1, 5'b01000));
        va.push_back(v(1'b0, 4'b0000, 1'b0, 5'b11010));   // p9 last bit frozen
        va.push_back(v(1'b0, 4'b0000, 1'b0, 5'b11010));
        va.push_back(v(1'b0, 4'b0000, 1'b1, 5'b11010));   // p11 drain hold
        va.push_back(v(1'b0, 4'b0000, 1'b0, 5'b01101));
        va.push_back(v(1'b0, 4'b0000, 1'b0, 5'b01101));
        va.push_back(v(1'b0, 4'b0000, 1'b1, 5'b01101));
        va.push_back(v(1'b0, 4'b0000, 1'b1, 5'b11001));
        va.push_back(v(1'b0, 4'b0000, 1'b1, 5'b11001));
        va.push_back(v(1'b1, 4'b1100, 1'b1, 5'b01011));   // p17 direct reload on last bit
        va.push_back(v(1'b0, 4'b0000, 1'b1, 5'b11101));
        va.push_back(v(1'b0, 4'b0000, 1'b1, 5'b11001));
        va.push_back(v(1'b0, 4'b0000, 1'b1, 5'b01001));
        va.push_back(v(1'b0, 4'b0000, 1'b1, 5'b01011));
        va.push_back(v(1'b0, 4'b0000, 1'b1, 5'b00001));

        // Idle level 1 before, between and after words.
        vc.push_back(v(1'b0, 4'b0000, 1'b1, 5'b10001));
        vc.push_back(v(1'b1, 4'b0101, 1'b1, 5'b10001));
        vc.push_back(v(1'b0, 4'b0000, 1'b1, 5'b01101));
        vc.push_back(v(1'b0, 4'b0000, 1'b1, 5'b11001));
        vc.push_back(v(1'b0, 4'b0000, 1'b1, 5'b01001));
        vc.push_back(v(1'b0, 4'b0000, 1'b1, 5'b11011));
        vc.push_back(v(1'b0, 4'b0000, 1'b1, 5'b10001));
        vc.push_back(v(1'b1, 4'b0110, 1'b1, 5'b10001));
        vc.push_back(v(1'b0, 4'b0000, 1'b1, 5'b01101));
        vc.push_back(v(1'b0, 4'b0000, 1'b1, 5'b11001));
        vc.push_back(v(1'b0, 4'b0000, 1'b1, 5'b11001));
        vc.push_back(v(1'b0, 4'b0000, 1'b1, 5'b01011));
        vc.push_back(v(1'b0, 4'b0000, 1'b1, 5'b10001));
        vc.push_back(v(1'b0, 4'b0000, 1'b0, 5'b10001));

        a_valid = 1'b0; a_data = '0; a_be = 1'b0;
        b_valid = 1'b0; b_data = '0; b_be = 1'b0;
        c_valid = 1'b0; c_data = '0; c_be = 1'b0;

        rst_n = 1'b0;
        #1;
        chk("reset_a", 0, {a_dout, a_dv, a_fs, a_fl, a_ready}, 5'b00001);
        chk("reset_b", 0, {b_dout, b_dv, b_fs, b_fl, b_ready}, 5'b00001);
        chk("reset_c", 0, {c_dout, c_dv, c_fs, c_fl, c_ready}, 5'b10001);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < va.size(); i++) begin
            a_valid = va[i].valid;
            a_data  = va[i].data;
            a_be    = va[i].be;
            #1;
            chk("vec_a", i, {a_dout, a_dv, a_fs, a_fl, a_ready}, va[i].exp);
            step();
        end
        a_valid = 1'b0; a_be = 1'b0;

        for (int i = 0; i < vc.size(); i++) begin
            c_valid = vc[i].valid;
            c_data  = vc[i].data;
            c_be    = vc[i].be;
            #1;
            chk("vec_c", i, {c_dout, c_dv, c_fs, c_fl, c_ready}, vc[i].exp);
            step();
        end
        c_valid = 1'b0; c_be = 1'b0;

        // Back-to-back 0xA5, 0x3C LSB first; valid held through the blocked cycles.
        b_bits = 16'b1010010100111100;
        for (int c = 0; c <= 17; c++) begin
            b_valid = (c <= 8);
            b_data  = (c == 0) ? 8'hA5 : 8'h3C;
            b_be    = 1'b1;
            #1;
            if (c == 0 || c == 17) begin
                b_exp = 5'b00001;
            end else begin
                b_exp = {b_bits[c-1], 1'b1, (c == 1 || c == 9), (c == 8 || c == 16),
                         !(c >= 2 && c <= 8)};
            end
            chk("b2b_b", c, {b_dout, b_dv, b_fs, b_fl, b_ready}, b_exp);
            step();
        end

        // Reset during bit 2 of 0xFF with a second word parked.
        b_valid = 1'b1; b_data = 8'hFF; b_be = 1'b1;
        step();
        b_data = 8'h81;
        step();
        b_valid = 1'b0;
        #1;
        chk("rst_hold_full", 0, {b_dout, b_dv, b_fs, b_fl, b_ready}, 5'b11000);
        step();
        #1;
        chk("rst_bit2", 0, {b_dout, b_dv, b_fs, b_fl, b_ready}, 5'b11000);
        rst_n = 1'b0;
        #1;
        chk("rst_async", 0, {b_dout, b_dv, b_fs, b_fl, b_ready}, 5'b00001);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("rst_after", i, {b_dout, b_dv, b_fs, b_fl, b_ready}, 5'b00001);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
